// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake, a one-entry skid buffer,
// a flush/reset bubble value, an occupancy output and a saturating stall counter.
module pipe_skid_reg #(
    parameter int unsigned          WIDTH     = 16,
    parameter logic [WIDTH-1:0]     FLUSH_VAL = '0,
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    input  logic                 cnt_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   main_q, main_nxt;
    logic [WIDTH-1:0]   skid_q, skid_nxt;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic               acc, pop;

    // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign occupancy = state;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    main_nxt  = in_data;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_nxt = in_data;
                end else if (acc) begin
                    state_nxt = TWO;
                    skid_nxt  = in_data;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = FLUSH_VAL;
            skid_nxt  = FLUSH_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= FLUSH_VAL;
            skid_q <= FLUSH_VAL;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_q <= '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: four parameter variants share one stimulus stream and
// are checked against a queue-based model of the held payloads.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush, cnt_clr;
    logic [63:0] in_data;

    logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov, d_ir, d_ov;
    logic [15:0] a_od, b_od;
    logic [0:0]  c_od;
    logic [63:0] d_od;
    logic [1:0]  a_oc, b_oc, c_oc, d_oc;
    logic [15:0] a_sc, c_sc, d_sc;
    logic [2:0]  b_sc;

    int          n_vec = 0;
    int          n_err = 0;

    logic [63:0] mq[$];
    logic [63:0] head = '0;
    bit          head_flush = 1'b1;
    longint      scnt = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(16), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data[15:0]),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .flush(flush),
        .occupancy(a_oc), .stall_cnt(a_sc), .cnt_clr(cnt_clr));

    pipe_skid_reg #(.WIDTH(16), .CNT_WIDTH(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data[15:0]),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .flush(flush),
        .occupancy(b_oc), .stall_cnt(b_sc), .cnt_clr(cnt_clr));

    pipe_skid_reg #(.WIDTH(1), .FLUSH_VAL(1'b1), .CNT_WIDTH(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data[0:0]),
        .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .flush(flush),
        .occupancy(c_oc), .stall_cnt(c_sc), .cnt_clr(cnt_clr));

    pipe_skid_reg #(.WIDTH(64), .FLUSH_VAL({64{1'b1}}), .CNT_WIDTH(16)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data),
        .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .flush(flush),
        .occupancy(d_oc), .stall_cnt(d_sc), .cnt_clr(cnt_clr));

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] e16, e1, e64, occ, vld, rdy;
        e16 = head_flush ? 64'h0 : {48'h0, head[15:0]};
        e1  = head_flush ? 64'h1 : {63'h0, head[0]};
        e64 = head_flush ? {64{1'b1}} : head;
        occ = 64'(mq.size());
        vld = 64'(mq.size() > 0);
        rdy = 64'(mq.size() < 2);
        chk("a_valid", 64'(a_ov), vld); chk("a_ready", 64'(a_ir), rdy);
        chk("a_occ", 64'(a_oc), occ);   chk("a_data", 64'(a_od), e16);
        chk("a_cnt", 64'(a_sc), 64'(sat(scnt, 65535)));
        chk("b_valid", 64'(b_ov), vld); chk("b_ready", 64'(b_ir), rdy);
        chk("b_occ", 64'(b_oc), occ);   chk("b_data", 64'(b_od), e16);
        chk("b_cnt", 64'(b_sc), 64'(sat(scnt, 7)));
        chk("c_valid", 64'(c_ov), vld); chk("c_ready", 64'(c_ir), rdy);
        chk("c_occ", 64'(c_oc), occ);   chk("c_data", 64'(c_od), e1);
        chk("c_cnt", 64'(c_sc), 64'(sat(scnt, 65535)));
        chk("d_valid", 64'(d_ov), vld); chk("d_ready", 64'(d_ir), rdy);
        chk("d_occ", 64'(d_oc), occ);   chk("d_data", d_od, e64);
        chk("d_cnt", 64'(d_sc), 64'(sat(scnt, 65535)));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then compare.
    task automatic step(input bit iv, input logic [63:0] d, input bit ordy,
                        input bit fl, input bit rs, input bit cc);
        int sz;
        bit acc, pop;
        in_valid = iv; in_data = d; out_ready = ordy;
        flush = fl; rst = rs; cnt_clr = cc;
        sz  = mq.size();
        acc = iv && (sz < 2);
        pop = (sz > 0) && ordy;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            head_flush = 1'b1;
            scnt = 0;
        end else begin
            if (cc) scnt = 0;
            else if ((sz > 0) && !ordy) scnt++;
            if (fl) begin
                mq.delete();
                head_flush = 1'b1;
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(d);
                if (mq.size() > 0) begin
                    head = mq[0];
                    head_flush = 1'b0;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        in_data = '0;
        #2;
        step(0, 64'h0, 0, 0, 1, 0);
        step(0, 64'h0, 0, 0, 0, 0);

        // Streaming 0x0001..0x0010 with out_ready held high.
        for (int i = 1; i <= 16; i++) step(1, 64'(i), 1, 0, 0, 0);
        step(0, 64'h0, 1, 0, 0, 0);
        chk("stream_cnt", 64'(a_sc), 64'h0);

        // Backpressure with 0xA1 at the head.
        step(1, 64'hA1, 1, 0, 0, 0);
        step(1, 64'hA2, 0, 0, 0, 0);
        chk("bp_occ2", 64'(a_oc), 64'h2);
        step(1, 64'hA3, 0, 0, 0, 0);
        step(1, 64'hA3, 0, 0, 0, 0);
        step(1, 64'hA3, 1, 0, 0, 0);
        chk("bp_head_a2", 64'(a_od), 64'hA2);
        step(1, 64'hA3, 1, 0, 0, 0);
        chk("bp_head_a3", 64'(a_od), 64'hA3);
        step(0, 64'h0, 1, 0, 0, 0);
        chk("bp_cnt", 64'(a_sc), 64'h3);

        // Flush while two entries are held, with a payload offered alongside.
        step(1, 64'h11, 0, 0, 0, 0);
        step(1, 64'h22, 0, 0, 0, 0);
        step(1, 64'hBEEF, 0, 1, 0, 0);
        chk("fl_valid", 64'(a_ov), 64'h0);
        chk("fl_d_data", d_od, {64{1'b1}});
        step(0, 64'h0, 1, 0, 0, 0);
        step(0, 64'h0, 1, 0, 0, 0);

        // Reset mid-operation with two entries held and stall count at 5.
        step(0, 64'h0, 1, 0, 0, 1);
        step(1, 64'hC1, 0, 0, 0, 0);
        step(1, 64'hC2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 64'h0, 0, 0, 0, 0);
        chk("rst_pre_cnt", 64'(a_sc), 64'h5);
        step(0, 64'h0, 0, 0, 1, 0);
        chk("rst_cnt", 64'(a_sc), 64'h0);

        // Counter saturation on the 3-bit variant, then clear.
        step(1, 64'h5A, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 64'h0, 0, 0, 0, 0);
        chk("sat7", 64'(b_sc), 64'h7);
        step(0, 64'h0, 0, 0, 0, 1);
        chk("clr0", 64'(b_sc), 64'h0);
        step(0, 64'h0, 1, 0, 0, 0);

        // Randomised traffic with occasional flush, reset and counter clear.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
